mmu_stream_loader: RTL
======================

// Module: mmu_stream_loader
// PURPOSE
//  Upstream feeder for the processing_element array. Accepts a valid/ready beat stream
//  and drives ap_start, ap_ctrl and the per-column col_read buses through the PE load
//  phases: initial-C (ARRAY_SIZE beats), A (MATRIX_DEPTH beats), B (MATRIX_DEPTH beats).
//  Then watches the array state and pulses done when the array returns to INIT.
// PARAMETERS
//  DATA_WIDTH    16    width of one column lane
//  ARRAY_SIZE    16    number of array columns (lanes per beat) = C-phase beat count
//  MATRIX_DEPTH  8000  beat count of each of the A and B phases
// PORTS
//  clk        in   1                     clock
//  rst_n      in   1                     synchronous, active-low reset
//  start      in   1                     1-cycle request; honoured only in IDLE
//  s_data     in   DATA_WIDTH*ARRAY_SIZE beat payload; lane j = bits [j*DW +: DW] -> column j
//  s_valid    in   1                     beat valid
//  s_last     in   1                     expected high on final B beat only
//  s_ready    out  1                     beat accepted when s_valid&&s_ready
//  pe_state   in   8                     ap_state of PE(0,0); one-hot, INIT=8'h01, OUT=8'h80
//  ap_start   out  1                     to all PEs
//  ap_ctrl    out  1                     to all PEs; 1 = col_data valid, PEs advance p
//  col_data   out  DATA_WIDTH*ARRAY_SIZE to col_read of the row-0 PE in each column
//  busy       out  1                     high in every state except IDLE
//  done       out  1                     1-cycle pulse at end of job
//  len_err    out  1                     sticky: s_last misplaced; cleared by reset or accepted start
// BEHAVIOUR
//  Reset: state=IDLE; ap_start, ap_ctrl, col_data, s_ready, busy, done, len_err and
//   beat_cnt all 0. Reset mid-job aborts at once, no done. The PE array is reset
//   separately.
//  States: IDLE -> LOAD_C -> LOAD_A -> LOAD_B -> WAIT_OUT -> WAIT_INIT -> IDLE.
//  IDLE: s_ready=0. On start: go to LOAD_C, beat_cnt=0, len_err=0.
//  LOAD_C/LOAD_A/LOAD_B: s_ready=1 (registered, set on entry). An accepted beat
//   registers col_data<=s_data and ap_ctrl<=1 for exactly the next cycle, so latency
//   is 1. With no accepted beat, ap_ctrl<=0 and col_data holds. The PE array must never
//   see ap_ctrl=1 with stale data.
//  beat_cnt counts accepted beats and is log2(MATRIX_DEPTH)+1 bits.
//   LOAD_C ends on the ARRAY_SIZE-th beat; LOAD_A and LOAD_B end on the MATRIX_DEPTH-th.
//   beat_cnt clears on each transition.
//  On the last B beat, s_ready drops the same cycle; no further beat is accepted.
//  ap_start: 1 throughout LOAD_C, aligned with ap_ctrl, so it is high on the PE's
//   final INIT beat. It is 0 in every other state.
//  s_last: any accepted beat with s_last != (LOAD_B && final beat) sets len_err.
//   Counting is unaffected; beat counts are authoritative.
//  WAIT_OUT: ap_ctrl=0, s_ready=0. Go to WAIT_INIT when pe_state==8'h80.
//  WAIT_INIT: when pe_state==8'h01, done=1 for one cycle, busy drops the same cycle,
//   and the state returns to IDLE.
//  A start outside IDLE is ignored. s_valid outside LOAD_* is ignored.
//  Back-pressure from s_valid gaps is arbitrary. A gap at a phase boundary is legal;
//   the next phase begins on the next accepted beat.
// TESTING (ARRAY_SIZE=4, MATRIX_DEPTH=8, DATA_WIDTH=16)
//  1. start, then 20 back-to-back beats (data=beat index per lane), s_last on beat 20.
//     Expect 20 ap_ctrl cycles each 1 after acceptance, ap_start high on ctrl cycles 1-4,
//     len_err=0, and s_ready low after beat 20.
//  2. As 1 with s_valid toggling 1,0,1,0. Expect ap_ctrl to mirror the accepted beats
//     delayed by 1, col_data held during gaps, and 20 ctrl pulses total.
//  3. After loading, drive pe_state 8'h08 -> 8'h80 x4 -> 8'h01. Expect done exactly 1 cycle
//     on the 8'h01 cycle, busy falling the same cycle, and state IDLE.
//  4. s_last asserted on beat 12, none on beat 20. Expect len_err=1 from beat 12 and
//     phase counts unchanged. A new start clears it.
//  5. start pulsed during LOAD_A. Expect it ignored and beat_cnt undisturbed.
//  6. rst_n low for 1 cycle mid-LOAD_B. Expect all outputs 0 next cycle and no done.
//     A fresh job then completes normally.

Source files
------------

// File: rtl/mmu_stream_loader.sv
// mmu_stream_loader
//   Feeds the processing_element array from a valid/ready beat stream. A job
//   runs three load phases: initial-C (ARRAY_SIZE beats), then A and B
//   (MATRIX_DEPTH beats each). After loading, it waits for the array to pass
//   through OUT and return to INIT, and then pulses done.
// Ports
//   clk, rst_n  clock and synchronous active-low reset
//   start       request a job (honoured only in IDLE)
//   s_data      beat payload; lane j -> column j
//   s_valid     beat valid
//   s_last      beat marker; expected only on the final B beat
//   s_ready     beat accepted when s_valid && s_ready
//   pe_state    one-hot ap_state of PE(0,0)
//   ap_start    PE start (high through LOAD_C, aligned with ap_ctrl)
//   ap_ctrl     PE advance strobe; col_data is valid whenever it is high
//   col_data    column read buses
//   busy        job in progress
//   done        single-cycle end-of-job pulse
//   len_err     sticky s_last placement error
module mmu_stream_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int ARRAY_SIZE   = 16,
  parameter int MATRIX_DEPTH = 8000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] s_data,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  input  logic [7:0]                       pe_state,
  output logic                             ap_start,
  output logic                             ap_ctrl,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] col_data,
  output logic                             busy,
  output logic                             done,
  output logic                             len_err
);

  localparam int CW = $clog2(MATRIX_DEPTH) + 1;
  localparam logic [7:0] PE_INIT = 8'h01;
  localparam logic [7:0] PE_OUT  = 8'h80;

  typedef enum logic [2:0] {
    IDLE, LOAD_C, LOAD_A, LOAD_B, WAIT_OUT, WAIT_INIT
  } state_t;

  state_t                           state, state_n;
  logic [CW-1:0]                    beat_cnt, beat_cnt_n;
  logic                             s_ready_n, ap_ctrl_n, ap_start_n, len_err_n;
  logic [DATA_WIDTH*ARRAY_SIZE-1:0] col_data_n;
  logic                             accept, final_beat;

  assign accept     = s_valid && s_ready;
  assign final_beat = (state == LOAD_C) ? (beat_cnt == CW'(ARRAY_SIZE - 1))
                                        : (beat_cnt == CW'(MATRIX_DEPTH - 1));

  // done/busy are decoded from state so done lands on the INIT cycle itself
  // and busy falls in that same cycle.
  assign done = (state == WAIT_INIT) && (pe_state == PE_INIT);
  assign busy = (state != IDLE) && !done;

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    s_ready_n  = s_ready;
    ap_ctrl_n  = accept;
    col_data_n = accept ? s_data : col_data;
    ap_start_n = (state == LOAD_C);
    len_err_n  = len_err;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = LOAD_C;
          beat_cnt_n = '0;
          s_ready_n  = 1'b1;
          len_err_n  = 1'b0;
        end
      end
      LOAD_C, LOAD_A, LOAD_B: begin
        if (accept) begin
          if (s_last != ((state == LOAD_B) && final_beat)) len_err_n = 1'b1;
          if (final_beat) begin
            beat_cnt_n = '0;
            unique case (state)
              LOAD_C:  state_n = LOAD_A;
              LOAD_A:  state_n = LOAD_B;
              default: begin
                state_n   = WAIT_OUT;
                s_ready_n = 1'b0;
              end
            endcase
          end else begin
            beat_cnt_n = beat_cnt + CW'(1);
          end
        end
      end
      WAIT_OUT:  if (pe_state == PE_OUT)  state_n = WAIT_INIT;
      WAIT_INIT: if (pe_state == PE_INIT) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      s_ready  <= 1'b0;
      ap_ctrl  <= 1'b0;
      ap_start <= 1'b0;
      col_data <= '0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      s_ready  <= s_ready_n;
      ap_ctrl  <= ap_ctrl_n;
      ap_start <= ap_start_n;
      col_data <= col_data_n;
      len_err  <= len_err_n;
    end
  end

endmodule
